// File: rtl/stall_pkg.sv
// Shared types and constants for the pipeline hazard/stall controller.
package stall_pkg;

    localparam int unsigned MD_LATENCY_DEFAULT = 4;
    localparam int unsigned MD_CNT_W           = 8;

    typedef enum logic {
        RUN     = 1'b0,
        MD_WAIT = 1'b1
    } state_t;

    typedef logic [1:0] hz_t;

    localparam hz_t HZ_NONE   = 2'd0;
    localparam hz_t HZ_BRANCH = 2'd1;
    localparam hz_t HZ_MD     = 2'd2;
    localparam hz_t HZ_LOAD   = 2'd3;

    // Resolve simultaneous hazard requests: branch squashes younger work, then mult/div, then load-use.
    function automatic hz_t hz_select(input logic branch, input logic md, input logic load);
        if (branch) begin
            return HZ_BRANCH;
        end else if (md) begin
            return HZ_MD;
        end else if (load) begin
            return HZ_LOAD;
        end
        return HZ_NONE;
    endfunction

endpackage

// File: rtl/md_latency_counter.sv
// Loadable down-counter with zero flag; sequences multi-cycle EX occupancy.
module md_latency_counter
    import stall_pkg::*;
#(
    parameter int unsigned W = MD_CNT_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         zero_c
);

    logic [W-1:0] cnt;

    // Load wins over decrement; decrement saturates at zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (dec && !zero_c) begin
            cnt <= cnt - W'(1);
        end
    end

    assign zero_c = (cnt == '0);

endmodule

// File: rtl/pipeline_stall_ctrl.sv
// Hazard-to-stage control for the 5-stage pipeline (Mealy outputs).
// Optional performance counters enabled by STALL_PERF_CNT_EN.
module pipeline_stall_ctrl
    import stall_pkg::*;
#(
    parameter int unsigned MD_LATENCY = MD_LATENCY_DEFAULT,
    parameter int unsigned CNT_W      = 32
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             LoadUse_Hazard,
    input  logic             Branch_Taken,
    input  logic             MD_Start,
    output logic             PC_Write,
    output logic             IFID_Write,
    output logic             IFID_Flush,
    output logic             IDEX_Write,
    output logic             IDEX_Bubble,
    output logic             EXMEM_Bubble,
    output logic             MD_Busy,
    output logic [CNT_W-1:0] Stall_Count,
    output logic [CNT_W-1:0] Flush_Count
);

    // The start cycle is one freeze cycle and the zero-count cycle is another.
    localparam logic [MD_CNT_W-1:0] MD_LOAD = MD_CNT_W'(MD_LATENCY - 2);

    state_t state, state_nxt;
    hz_t    hz;
    logic   md_release;
    logic   md_load, md_dec, md_zero_c;

    md_latency_counter #(.W(MD_CNT_W)) u_md_cnt (
        .clk      (Clk),
        .rst      (Reset),
        .load     (md_load),
        .load_val (MD_LOAD),
        .dec      (md_dec),
        .zero_c   (md_zero_c)
    );

    // md_release marks the first RUN cycle after a freeze, masking the still-present MD_Start.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state      <= RUN;
            md_release <= 1'b0;
        end else begin
            state      <= state_nxt;
            md_release <= (state == MD_WAIT) && (state_nxt == RUN);
        end
    end

    always_comb begin
        state_nxt    = state;
        PC_Write     = 1'b0;
        IFID_Write   = 1'b0;
        IFID_Flush   = 1'b0;
        IDEX_Write   = 1'b0;
        IDEX_Bubble  = 1'b0;
        EXMEM_Bubble = 1'b0;
        MD_Busy      = 1'b0;
        md_load      = 1'b0;
        md_dec       = 1'b0;
        hz           = hz_select(Branch_Taken, MD_Start && !md_release, LoadUse_Hazard);

        if (Reset) begin
            state_nxt = RUN;
        end else begin
            case (state)
                RUN: begin
                    PC_Write   = 1'b1;
                    IFID_Write = 1'b1;
                    IDEX_Write = 1'b1;
                    case (hz)
                        HZ_BRANCH: begin
                            IFID_Flush  = 1'b1;
                            IDEX_Bubble = 1'b1;
                        end
                        HZ_MD: begin
                            PC_Write     = 1'b0;
                            IFID_Write   = 1'b0;
                            IDEX_Write   = 1'b0;
                            EXMEM_Bubble = 1'b1;
                            md_load      = 1'b1;
                            state_nxt    = MD_WAIT;
                        end
                        HZ_LOAD: begin
                            PC_Write    = 1'b0;
                            IFID_Write  = 1'b0;
                            IDEX_Bubble = 1'b1;
                        end
                        default: ;
                    endcase
                end
                MD_WAIT: begin
                    EXMEM_Bubble = 1'b1;
                    MD_Busy      = 1'b1;
                    if (md_zero_c) begin
                        state_nxt = RUN;
                    end else begin
                        md_dec = 1'b1;
                    end
                end
                default: state_nxt = RUN;
            endcase
        end
    end

`ifdef STALL_PERF_CNT_EN
    // Free-running wrap-around event counters; PC_Write is already low during reset.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            Stall_Count <= '0;
            Flush_Count <= '0;
        end else begin
            if (!PC_Write) begin
                Stall_Count <= Stall_Count + CNT_W'(1);
            end
            if (IFID_Flush) begin
                Flush_Count <= Flush_Count + CNT_W'(1);
            end
        end
    end
`else
    assign Stall_Count = '0;
    assign Flush_Count = '0;
`endif

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// Directed bench for pipeline_stall_ctrl with a cycle-level behavioural model and literal spot checks.
module tb_pipeline_stall_ctrl;

    localparam int unsigned L  = 4;
    localparam int unsigned CW = 32;

    logic Clk = 1'b0;
    logic Reset = 1'b1;
    logic LoadUse_Hazard = 1'b0;
    logic Branch_Taken = 1'b0;
    logic MD_Start = 1'b0;
    logic PC_Write, IFID_Write, IFID_Flush, IDEX_Write, IDEX_Bubble, EXMEM_Bubble, MD_Busy;
    logic [CW-1:0] Stall_Count, Flush_Count;

    pipeline_stall_ctrl #(.MD_LATENCY(L), .CNT_W(CW)) dut (
        .Clk            (Clk),
        .Reset          (Reset),
        .LoadUse_Hazard (LoadUse_Hazard),
        .Branch_Taken   (Branch_Taken),
        .MD_Start       (MD_Start),
        .PC_Write       (PC_Write),
        .IFID_Write     (IFID_Write),
        .IFID_Flush     (IFID_Flush),
        .IDEX_Write     (IDEX_Write),
        .IDEX_Bubble    (IDEX_Bubble),
        .EXMEM_Bubble   (EXMEM_Bubble),
        .MD_Busy        (MD_Busy),
        .Stall_Count    (Stall_Count),
        .Flush_Count    (Flush_Count)
    );

    always #5 Clk = ~Clk;

    int vectors = 0;
    int miscompares = 0;

    typedef struct packed {
        logic pcw;
        logic ifidw;
        logic flush;
        logic idexw;
        logic bub;
        logic exb;
        logic busy;
    } ctl_t;

    // Model state: freeze cycles still owed after the current one, and "op just left EX freeze".
    int     freeze_left = 0;
    bit     just_rel = 1'b0;
    longint stall_m = 0;
    longint flush_m = 0;
    ctl_t   exp_now = '0;

    function automatic ctl_t model(input logic r, input logic br, input logic md, input logic lu,
                                   input int fl, input bit jr);
        ctl_t e;
        e = '0;
        if (r) return e;
        if (fl > 0) begin
            e.exb  = 1'b1;
            e.busy = 1'b1;
            return e;
        end
        e.pcw = 1'b1; e.ifidw = 1'b1; e.idexw = 1'b1;
        if (br) begin
            e.flush = 1'b1; e.bub = 1'b1;
        end else if (md && !jr) begin
            e.pcw = 1'b0; e.ifidw = 1'b0; e.idexw = 1'b0; e.exb = 1'b1;
        end else if (lu) begin
            e.pcw = 1'b0; e.ifidw = 1'b0; e.bub = 1'b1;
        end
        return e;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Every-cycle compare, mid-low-phase after inputs settle.
    always @(negedge Clk) begin
        logic [CW-1:0] es, ef;
        #2;
        exp_now = model(Reset, Branch_Taken, MD_Start, LoadUse_Hazard, freeze_left, just_rel);
        chk("model_ctl", {PC_Write, IFID_Write, IFID_Flush, IDEX_Write, IDEX_Bubble, EXMEM_Bubble, MD_Busy},
            64'(exp_now));
        chk("bubble_vs_idex_write", 64'(IDEX_Bubble & ~IDEX_Write), 64'd0);
`ifdef STALL_PERF_CNT_EN
        es = Reset ? '0 : CW'(stall_m);
        ef = Reset ? '0 : CW'(flush_m);
`else
        es = '0;
        ef = '0;
`endif
        chk("model_stall_cnt", 64'(Stall_Count), 64'(es));
        chk("model_flush_cnt", 64'(Flush_Count), 64'(ef));
    end

    always @(posedge Clk) begin
        if (Reset) begin
            freeze_left = 0; just_rel = 1'b0; stall_m = 0; flush_m = 0;
        end else begin
            if (!exp_now.pcw) stall_m++;
            if (exp_now.flush) flush_m++;
            if (freeze_left > 0) begin
                freeze_left--;
                just_rel = (freeze_left == 0);
            end else begin
                just_rel = 1'b0;
                if (exp_now.exb) freeze_left = int'(L) - 1;
            end
        end
    end

    // Drive one cycle of inputs at the falling edge; returns after the compare point.
    task automatic cyc(input logic r, input logic br, input logic md, input logic lu);
        @(negedge Clk);
        Reset = r; Branch_Taken = br; MD_Start = md; LoadUse_Hazard = lu;
        #3;
    endtask

    logic [3:0] tbl [12];

    initial begin
        int low, busy, fl;

        repeat (3) begin
            cyc(1'b1, 1'b0, 1'b0, 1'b0);
            chk("rst_enables", {PC_Write, IFID_Write, IDEX_Write, MD_Busy}, 64'd0);
        end
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        chk("run_enables", {PC_Write, IFID_Write, IDEX_Write}, 64'b111);
        chk("run_bubbles", {IFID_Flush, IDEX_Bubble, EXMEM_Bubble}, 64'd0);

        cyc(1'b0, 1'b0, 1'b0, 1'b1);
        chk("lu_ctl", {PC_Write, IFID_Write, IDEX_Write, IDEX_Bubble}, 64'b0011);
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        chk("lu_release", {PC_Write, IFID_Write, IDEX_Bubble}, 64'b110);
`ifdef STALL_PERF_CNT_EN
        chk("lu_stall_cnt", 64'(Stall_Count), 64'd1);
`endif

        // MD_Start held while the op sits in EX, including the first cycle it advances.
        low = 0; busy = 0;
        for (int i = 0; i < 5; i++) begin
            cyc(1'b0, 1'b0, 1'b1, 1'b0);
            low  += int'(!PC_Write);
            busy += int'(MD_Busy);
            if (i < 4) chk("md_exb", 64'(EXMEM_Bubble), 64'd1);
            if (i == 4) chk("md_run5", {PC_Write, EXMEM_Bubble, MD_Busy}, 64'b100);
        end
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        chk("md_freeze_len", 64'(low), 64'd4);
        chk("md_busy_len", 64'(busy), 64'd3);

        cyc(1'b0, 1'b1, 1'b1, 1'b1);
        chk("br_ctl", {IFID_Flush, IDEX_Bubble, PC_Write, EXMEM_Bubble}, 64'b1110);
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        chk("br_no_md", {MD_Busy, PC_Write}, 64'b01);
`ifdef STALL_PERF_CNT_EN
        chk("br_flush_cnt", 64'(Flush_Count), 64'd1);
        chk("stall_cnt_5", 64'(Stall_Count), 64'd5);
`endif

        // Branch during MD_WAIT cycle 2 is ignored.
        low = 0; fl = 0;
        for (int i = 0; i < 5; i++) begin
            cyc(1'b0, (i == 2), 1'b1, 1'b0);
            low += int'(!PC_Write);
            fl  += int'(IFID_Flush);
        end
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        chk("md_br_freeze_len", 64'(low), 64'd4);
        chk("md_br_no_flush", 64'(fl), 64'd0);

        // Reset in MD_WAIT cycle 2.
        cyc(1'b0, 1'b0, 1'b1, 1'b0);
        cyc(1'b0, 1'b0, 1'b1, 1'b0);
        cyc(1'b1, 1'b0, 1'b1, 1'b0);
        chk("rst_md_ctl", {PC_Write, MD_Busy, EXMEM_Bubble, IDEX_Write}, 64'd0);
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        chk("post_rst_ctl", {PC_Write, IFID_Write, IDEX_Write, MD_Busy, EXMEM_Bubble}, 64'b11100);
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        chk("post_rst_run", 64'(PC_Write), 64'd1);
`ifdef STALL_PERF_CNT_EN
        chk("post_rst_stall_cnt", 64'(Stall_Count), 64'd0);
`endif

        // Mixed patterns {br, md, lu, unused}; checked by the per-cycle model.
        tbl = '{4'b0010, 4'b0010, 4'b1000, 4'b0110, 4'b0000, 4'b0000,
                4'b0000, 4'b0000, 4'b1010, 4'b0010, 4'b1100, 4'b0000};
        foreach (tbl[i]) begin
            logic [3:0] v;
            v = tbl[i];
            cyc(1'b0, v[3], v[2], v[1]);
        end
        repeat (2) cyc(1'b0, 1'b0, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
